d_gi_fifo: RTL and testbench
============================

// Module: d_gi_fifo
// PURPOSE
//  Global-input buffer: the producer side of the empty_n/read handshake that the
//  main-controller read mux consumes as empty_n_from_gi / read_for_gi.
//  Synchronous first-word-fall-through FIFO.
//  - Write side: full_n/write, fed by the DMA/stream unpacker.
//  - Read side: empty_n/read, routed by the mux to the kernel, bias or
//    input-feature write module.
// PARAMETERS
//  DATA_WIDTH  64  width of one FIFO word (din/dout)
//  DEPTH_LOG2  4   log2 of storage depth; DEPTH = 2**DEPTH_LOG2 words
// PORTS
//  clk         in   1               single clock; all state updates on posedge clk
//  reset       in   1               synchronous, active-high reset
//  din         in   DATA_WIDTH      write data, sampled when write accepted
//  write       in   1               write request
//  full_n      out  1               1 = space available; write accepted iff write & full_n
//  dout        out  DATA_WIDTH      head-of-FIFO word, valid whenever empty_n=1
//  read        in   1               read request; pops iff read & empty_n
//  empty_n     out  1               1 = FIFO holds >=1 word (to empty_n_from_gi)
//  count       out  DEPTH_LOG2+1    current occupancy, 0..DEPTH
//  ovf_err     out  1               [GI_FIFO_STAT_EN only] sticky write-when-full flag
//  udf_err     out  1               [GI_FIFO_STAT_EN only] sticky read-when-empty flag
//  clr_err     in   1               [GI_FIFO_STAT_EN only] clears both sticky flags
// BEHAVIOUR
//  - Storage: DEPTH x DATA_WIDTH array.
//    - wr_ptr, rd_ptr: DEPTH_LOG2 bits each; wrap modulo DEPTH naturally.
//    - occupancy register: DEPTH_LOG2+1 bits.
//  - Reset (reset=1 at posedge):
//    - wr_ptr=rd_ptr=0, count=0, so empty_n=0 and full_n=1.
//    - Stored data is not cleared.
//    - Reset mid-transfer discards all contents; requests in the reset cycle are ignored.
//  - full_n = (count != DEPTH); empty_n = (count != 0). Both decode from registers,
//    with no combinational path from write/read.
//  - Accepted write (wa = write & full_n): mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1.
//  - Accepted read (ra = read & empty_n): rd_ptr <= rd_ptr+1.
//  - count update: wa&!ra -> +1; ra&!wa -> -1; both or neither -> unchanged.
//  - Latency: a word written at edge N sets empty_n=1 and appears on dout after edge N.
//    No same-cycle bypass: a write into an empty FIFO cannot be read in the same cycle.
//  - FWFT: dout = mem[rd_ptr], combinational from the registered rd_ptr.
//    dout is don't-care while empty_n=0.
//  - Boundary cases:
//    - Full (count=DEPTH) with write=1, read=1: the read pops and the write is rejected.
//      Next cycle count=DEPTH-1 and full_n=1.
//    - Empty with write=1, read=1: the read is ignored and the write is accepted (count=1).
//    - Write while full: data dropped; pointers and count unchanged.
//    - Read while empty: no effect.
//    - Mid-level simultaneous read and write: both take effect and count holds.
//    - Wrap: pointers roll DEPTH-1 -> 0 with order preserved.
//  - Producers must hold din/write until full_n=1.
//    Consumers may deassert read at any cycle.
// CONFIGURATION
//  - GI_FIFO_STAT_EN defined: ovf_err, udf_err and clr_err ports exist.
//    - ovf_err <= 1 on write & !full_n; udf_err <= 1 on read & !empty_n.
//    - Each flag holds until clr_err=1 or reset.
//    - Set has priority over clr_err in the same cycle.
//    - Both flags reset to 0.
//  - GI_FIFO_STAT_EN undefined: these ports and flags are absent.
//    Illegal requests are silently ignored as described above.
// TESTING (DATA_WIDTH=64, DEPTH_LOG2=2, so DEPTH=4)
//  1. Reset, then write 0xA1 for one cycle -> next cycle empty_n=1, dout=0xA1, count=1.
//     Pulse read -> empty_n=0, count=0.
//  2. Write 0x1..0x4 back-to-back -> full_n=0, count=4.
//     A 5th write of 0x5 is dropped. Reads then return 0x1,0x2,0x3,0x4 in order.
//  3. Full FIFO, write=read=1 for 1 cycle with din=0x9 -> 0x1 popped, 0x9 not stored,
//     count=3, full_n=1.
//  4. Empty FIFO, write=read=1 with din=0x7 -> count=1, dout=0x7.
//     Then stream 10 words with write=read=1 held -> output order intact across
//     pointer wrap, count stays 1.
//  5. Load 3 words, assert reset for 1 cycle while write=1 -> count=0, empty_n=0,
//     full_n=1; the din from the reset cycle is absent.
//  6. With GI_FIFO_STAT_EN: write when full -> ovf_err=1 next cycle.
//     Read when empty -> udf_err=1. clr_err=1 -> both flags 0.
//     ovf trigger and clr_err in the same cycle -> ovf_err stays 1.

Source files
------------

// File: rtl/d_gi_fifo_if.sv
// Global-input FIFO handshake bundle: write side (din/write/full_n) and FWFT read side.
// Error-status signals exist only when GI_FIFO_STAT_EN is defined.
interface d_gi_fifo_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  write;
    logic                  full_n;
    logic [DATA_WIDTH-1:0] dout;
    logic                  read;
    logic                  empty_n;
    logic [DEPTH_LOG2:0]   count;
`ifdef GI_FIFO_STAT_EN
    logic                  ovf_err;
    logic                  udf_err;
    logic                  clr_err;

    modport master (
        output din, write, read, clr_err,
        input  full_n, dout, empty_n, count, ovf_err, udf_err
    );
    modport slave (
        input  din, write, read, clr_err,
        output full_n, dout, empty_n, count, ovf_err, udf_err
    );
`else
    modport master (
        output din, write, read,
        input  full_n, dout, empty_n, count
    );
    modport slave (
        input  din, write, read,
        output full_n, dout, empty_n, count
    );
`endif
endinterface

// File: rtl/d_gi_fifo.sv
// Global-input buffer: synchronous first-word-fall-through FIFO feeding the controller read mux.
// Define GI_FIFO_STAT_EN to add sticky overflow/underflow flags with clr_err.
module d_gi_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic        clk,
    input logic        reset,
    d_gi_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         occ;
    logic                  full_n_c;
    logic                  empty_n_c;
    logic                  wa;
    logic                  ra;

    // Status decodes only from the occupancy register; no path from write/read.
    always_comb begin
        full_n_c  = (occ != CW'(DEPTH));
        empty_n_c = (occ != CW'(0));
        wa        = bus.write & full_n_c;
        ra        = bus.read & empty_n_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wa) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (ra) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({wa, ra})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is intentionally not cleared by reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && wa) mem[wr_ptr] <= bus.din;
    end

    assign bus.full_n  = full_n_c;
    assign bus.empty_n = empty_n_c;
    assign bus.count   = occ;
    assign bus.dout    = mem[rd_ptr];

`ifdef GI_FIFO_STAT_EN
    logic ovf_q;
    logic udf_q;

    // Sticky illegal-request flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.write && !full_n_c) ovf_q <= 1'b1;
            else if (bus.clr_err)       ovf_q <= 1'b0;
            if (bus.read && !empty_n_c) udf_q <= 1'b1;
            else if (bus.clr_err)       udf_q <= 1'b0;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`endif
endmodule

// File: tb/tb_d_gi_fifo.sv
// Scoreboard bench for d_gi_fifo: queue-based reference model, directed boundary cases, random traffic.
module tb_d_gi_fifo;
    localparam int unsigned DW    = 64;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    d_gi_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) bus ();

    d_gi_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] model_q[$];
`ifdef GI_FIFO_STAT_EN
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
`endif

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, updated from the request rules.
    always @(posedge clk) begin
        if (reset) begin
            model_q.delete();
`ifdef GI_FIFO_STAT_EN
            m_ovf = 1'b0;
            m_udf = 1'b0;
`endif
        end else begin
            automatic bit was_full  = (model_q.size() == DEPTH);
            automatic bit was_empty = (model_q.size() == 0);
            automatic logic [DW-1:0] wdata = bus.din;
`ifdef GI_FIFO_STAT_EN
            if (bus.write && was_full) m_ovf = 1'b1;
            else if (bus.clr_err)      m_ovf = 1'b0;
            if (bus.read && was_empty) m_udf = 1'b1;
            else if (bus.clr_err)      m_udf = 1'b0;
`endif
            if (bus.read && !was_empty) void'(model_q.pop_front());
            if (bus.write && !was_full) model_q.push_back(wdata);
        end
    end

    // Monitor: compares everything the DUT presents against the model on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count",   64'(bus.count),   64'(model_q.size()));
            check("empty_n", 64'(bus.empty_n), 64'(model_q.size() != 0));
            check("full_n",  64'(bus.full_n),  64'(model_q.size() != DEPTH));
            if (model_q.size() != 0) check("dout", bus.dout, model_q[0]);
`ifdef GI_FIFO_STAT_EN
            check("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
            check("udf_err", 64'(bus.udf_err), 64'(m_udf));
`endif
        end
    end

    // Drive one cycle at the falling edge, return at the next falling edge.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bus.write = w;
        bus.read  = r;
        bus.din   = d;
        reset     = rs;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.din   = '0;
`ifdef GI_FIFO_STAT_EN
        bus.clr_err = 1'b0;
`endif
        reset = 1'b1;
        @(negedge clk);
        cyc(1'b0, 1'b0, '0, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b1);
        check("rst_count",   64'(bus.count),   64'd0);
        check("rst_empty_n", 64'(bus.empty_n), 64'd0);
        check("rst_full_n",  64'(bus.full_n),  64'd1);

        // Single write then read
        cyc(1'b1, 1'b0, 64'hA1, 1'b0);
        check("t1_dout",  bus.dout, 64'hA1);
        check("t1_count", 64'(bus.count), 64'd1);
        cyc(1'b0, 1'b1, '0, 1'b0);
        check("t1_empty", 64'(bus.empty_n), 64'd0);

        // Fill, overflow write dropped, drain in order
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 64'(i), 1'b0);
        check("t2_full_n", 64'(bus.full_n), 64'd0);
        cyc(1'b1, 1'b0, 64'h5, 1'b0);
        check("t2_count", 64'(bus.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check("t2_order", bus.dout, 64'(i));
            cyc(1'b0, 1'b1, '0, 1'b0);
        end
        check("t2_drained", 64'(bus.empty_n), 64'd0);

        // Full with simultaneous read/write: read wins, write rejected
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 64'(i), 1'b0);
        cyc(1'b1, 1'b1, 64'h9, 1'b0);
        check("t3_count",  64'(bus.count),  64'd3);
        check("t3_full_n", 64'(bus.full_n), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            check("t3_order", bus.dout, 64'(i));
            cyc(1'b0, 1'b1, '0, 1'b0);
        end
        check("t3_no9", 64'(bus.empty_n), 64'd0);

        // Empty with simultaneous read/write, then streaming across wrap
        cyc(1'b1, 1'b1, 64'h7, 1'b0);
        check("t4_count", 64'(bus.count), 64'd1);
        check("t4_dout",  bus.dout, 64'h7);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 64'h100 + 64'(k), 1'b0);
            check("t4_stream", bus.dout, 64'h100 + 64'(k));
            check("t4_hold",   64'(bus.count), 64'd1);
        end
        cyc(1'b0, 1'b1, '0, 1'b0);

        // Reset mid-transfer discards contents and the reset-cycle write
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 64'hC0 + 64'(i), 1'b0);
        cyc(1'b1, 1'b0, 64'hDEAD, 1'b1);
        check("t5_count",   64'(bus.count),   64'd0);
        check("t5_empty_n", 64'(bus.empty_n), 64'd0);
        check("t5_full_n",  64'(bus.full_n),  64'd1);
        cyc(1'b1, 1'b0, 64'h55, 1'b0);
        check("t5_fresh", bus.dout, 64'h55);
        cyc(1'b0, 1'b1, '0, 1'b0);

`ifdef GI_FIFO_STAT_EN
        cyc(1'b0, 1'b1, '0, 1'b0);
        check("t6_udf", 64'(bus.udf_err), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 64'(i), 1'b0);
        cyc(1'b1, 1'b0, 64'h66, 1'b0);
        check("t6_ovf", 64'(bus.ovf_err), 64'd1);
        bus.clr_err = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        check("t6_clr_ovf", 64'(bus.ovf_err), 64'd0);
        check("t6_clr_udf", 64'(bus.udf_err), 64'd0);
        cyc(1'b1, 1'b0, 64'h67, 1'b0);
        check("t6_set_wins", 64'(bus.ovf_err), 64'd1);
        bus.clr_err = 1'b0;
`endif

        // Random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
`ifdef GI_FIFO_STAT_EN
            bus.clr_err = ($urandom_range(0, 15) == 0);
`endif
            cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                {$urandom(), $urandom()}, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
